i2s_dac_tx: RTL and testbench

Output end of the effects chain: accepts processed 16-bit signed samples from the effects pipeline and serializes them to an external audio DAC/codec in standard I2S format. It generates BCLK, LRCLK and SDATA from the system clock. Each mono sample is sent to both left and right slots. A one-deep holding register decouples the pipeline's sample strobe from the frame timing, and underrun/overrun are flagged.

---
 rtl/i2s_dac_tx.sv | 120 ++++++++++++
 tb/tb_i2s_dac_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the effects-chain output: serializes each mono 16-bit sample
// into both slots of a standard (1-bit delayed) I2S frame, with a one-deep holding register.
module i2s_dac_tx #(
    parameter int bclk_div = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [15:0] sample_in,
    output logic        ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun,
    output logic        overrun
);

    localparam int DW = (bclk_div > 1) ? $clog2(bclk_div) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(bclk_div - 1);
    localparam logic [DW-1:0] DIV_ONE = DW'(1);

    logic [DW-1:0] div_cnt_r;
    logic          bclk_r;
    logic [4:0]    bit_cnt_r;
    logic          lrclk_r;
    logic [31:0]   shift_r;
    logic [15:0]   hold_r;
    logic          full_r;
    logic [15:0]   last_r;
    logic          load_empty_r;
    logic          underrun_r;
    logic          overrun_r;
    logic          ready_r;

    logic          div_wrap_s;
    logic          fall_s;
    logic          load_s;
    logic [4:0]    bit_cnt_nx_s;
    logic [15:0]   word_s;
    logic [15:0]   hold_nx_s;
    logic          full_nx_s;
    logic          drop_s;

    assign div_wrap_s   = (div_cnt_r == DIV_MAX);
    assign fall_s       = div_wrap_s & bclk_r;
    // The falling edge that ends period 0 is the frame load point.
    assign load_s       = fall_s & (bit_cnt_r == 5'd0);
    assign bit_cnt_nx_s = bit_cnt_r + 5'd1;
    assign word_s       = full_r ? hold_r : last_r;

    // Holding-register next state: capture, drop on overrun, or hand off at the load point.
    always_comb begin
        hold_nx_s = hold_r;
        full_nx_s = full_r;
        drop_s    = 1'b0;
        if (load_s) begin
            if (valid) begin
                hold_nx_s = sample_in;
                full_nx_s = 1'b1;
            end else begin
                full_nx_s = 1'b0;
            end
        end else if (valid) begin
            if (full_r) begin
                drop_s = 1'b1;
            end else begin
                hold_nx_s = sample_in;
                full_nx_s = 1'b1;
            end
        end else begin
            full_nx_s = full_r;
        end
    end

    // Clock divider, bit/frame sequencing, shift register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r    <= {DW{1'b0}};
            bclk_r       <= 1'b0;
            bit_cnt_r    <= 5'd0;
            lrclk_r      <= 1'b0;
            shift_r      <= 32'd0;
            hold_r       <= 16'd0;
            full_r       <= 1'b0;
            last_r       <= 16'd0;
            load_empty_r <= 1'b0;
            underrun_r   <= 1'b0;
            overrun_r    <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            div_cnt_r <= div_wrap_s ? {DW{1'b0}} : (div_cnt_r + DIV_ONE);
            if (div_wrap_s) begin
                bclk_r <= ~bclk_r;
            end
            if (fall_s) begin
                bit_cnt_r <= bit_cnt_nx_s;
                lrclk_r   <= bit_cnt_nx_s[4];
                shift_r   <= load_s ? {word_s, word_s} : {shift_r[30:0], 1'b0};
            end
            if (load_s) begin
                last_r <= word_s;
            end
            hold_r       <= hold_nx_s;
            full_r       <= full_nx_s;
            ready_r      <= ~full_nx_s;
            // Underrun is reported one cycle after the edge on which the frame loaded.
            load_empty_r <= load_s & ~full_r;
            underrun_r   <= load_empty_r;
            overrun_r    <= drop_s;
        end
    end

    assign bclk     = bclk_r;
    assign lrclk    = lrclk_r;
    assign sdata    = shift_r[31];
    assign ready    = ready_r;
    assign underrun = underrun_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: directed scenarios plus random traffic, checked cycle by cycle
// against a frame-level model of the I2S output.
module tb_i2s_dac_tx;

    localparam int D     = 2;
    localparam int FRAME = 64 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] sample_in = 16'd0;
    logic        ready, bclk, lrclk, sdata, underrun, overrun;

    i2s_dac_tx #(.bclk_div(D)) dut (
        .clk(clk), .rst(rst), .valid(valid), .sample_in(sample_in),
        .ready(ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .underrun(underrun), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int          t;
    logic        m_full;
    logic [15:0] m_hold;
    logic [15:0] m_last;
    logic [15:0] frame_word [0:255];
    int          ur_at;
    int          ov_at;
    logic [15:0] sched [int];
    bit          rand_mode;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; m_full = 1'b0; m_hold = 16'd0; m_last = 16'd0;
        ur_at = -1; ov_at = -1;
        for (int i = 0; i < 256; i++) frame_word[i] = 16'd0;
    endtask

    function automatic logic exp_sdata(input int tc);
        int n, m, b;
        logic [15:0] s;
        n = tc / (2 * D);
        m = n / 32;
        b = n % 32;
        if (b == 0) begin
            if (m == 0) return 1'b0;
            s = frame_word[m-1];
            return s[0];
        end
        s = frame_word[m];
        return s[(32 - b) % 16];
    endfunction

    task automatic check_outputs();
        int n;
        n = t / (2 * D);
        check_val("bclk", {31'd0, bclk}, {31'd0, 1'((t / D) % 2)});
        check_val("lrclk", {31'd0, lrclk}, {31'd0, 1'((n % 32) >= 16)});
        check_val("sdata", {31'd0, sdata}, {31'd0, exp_sdata(t)});
        check_val("ready", {31'd0, ready}, {31'd0, ~m_full});
        check_val("underrun", {31'd0, underrun}, {31'd0, 1'(t == ur_at)});
        check_val("overrun", {31'd0, overrun}, {31'd0, 1'(t == ov_at)});
    endtask

    task automatic run(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            check_outputs();
            if (sched.exists(t)) begin
                valid = 1'b1; sample_in = sched[t];
            end else if (rand_mode && $urandom_range(0, 79) == 0) begin
                valid = 1'b1; sample_in = 16'($urandom);
            end else begin
                valid = 1'b0; sample_in = 16'($urandom);
            end
            // frame-level reference: load point is the last cycle of period 0 in each frame
            if ((t % FRAME) == (2 * D - 1)) begin
                if (m_full) begin
                    frame_word[t / FRAME] = m_hold;
                end else begin
                    frame_word[t / FRAME] = m_last;
                    ur_at = t + 2;
                end
                m_last = frame_word[t / FRAME];
                m_full = valid;
                if (valid) m_hold = sample_in;
            end else if (valid) begin
                if (m_full) ov_at = t + 1;
                else begin m_hold = sample_in; m_full = 1'b1; end
            end
            t++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_val("rst_bclk", {31'd0, bclk}, 32'd0);
            check_val("rst_lrclk", {31'd0, lrclk}, 32'd0);
            check_val("rst_sdata", {31'd0, sdata}, 32'd0);
            check_val("rst_ready", {31'd0, ready}, 32'd1);
            check_val("rst_flags", {30'd0, underrun, overrun}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sched.delete();
    endtask

    initial begin
        rand_mode = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // single sample, then repeat with underrun
        sched[0] = 16'hA5F0;
        run(3 * FRAME);

        // mid-frame reset, then starvation
        run(FRAME / 2 + 7);
        do_reset();
        run(3 * FRAME + 8);

        // overrun: two consecutive non-load valids
        do_reset();
        sched[10] = 16'h1234;
        sched[11] = 16'h7FFF;
        run(3 * FRAME);

        // load collision: full holding register and valid on the load cycle
        do_reset();
        sched[20] = 16'h0001;
        sched[FRAME + 2 * D - 1] = 16'h8000;
        run(4 * FRAME);

        // repeat after a single load
        do_reset();
        sched[50] = 16'h00FF;
        run(3 * FRAME);

        // random traffic
        do_reset();
        rand_mode = 1'b1;
        run(8 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
